// File: rtl/alu_packet_engine.sv
// alu_packet_engine: framed command processor between the UART RX and TX byte
// streams. Parses OPCODE/RSVD/LEN_LO/LEN_HI headers. Depending on the opcode it
// echoes the payload, reduces 32-bit words by add or multiply, or drains the
// payload of a malformed packet.
`timescale 1ns/1ps
module alu_packet_engine #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_MUL  = 8'h88;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RSVD   = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_LEN_HI = 3'd3;
    localparam logic [2:0] S_ECHO   = 3'd4;
    localparam logic [2:0] S_ACCUM  = 3'd5;
    localparam logic [2:0] S_RESULT = 3'd6;
    localparam logic [2:0] S_DRAIN  = 3'd7;

    logic [2:0]  state;
    logic [7:0]  opcode;
    logic [7:0]  len_lo;
    logic [15:0] cnt;       // payload bytes still to consume
    logic [31:0] acc;
    logic [23:0] part;      // first three bytes of the word being assembled
    logic [1:0]  byte_idx;  // byte position inside the current operand word
    logic [1:0]  tx_idx;    // result byte currently offered on tx
    logic        err_q;

    logic [15:0] len_w;
    logic [15:0] pay_w;
    logic        is_arith;
    logic [31:0] word_w;
    logic [31:0] acc_next;
    logic        rx_fire;
    logic        tx_fire;

    assign len_w    = {rx_data_i, len_lo};
    assign pay_w    = len_w - 16'd4;
    assign is_arith = (opcode == OP_ADD) || (opcode == OP_MUL);
    assign word_w   = {rx_data_i, part};
    // Multiply keeps only the low 32 bits: both operands are 32 bits wide.
    assign acc_next = (opcode == OP_MUL) ? acc * word_w : acc + word_w;
    assign rx_fire  = rx_valid_i & rx_ready_o;
    assign tx_fire  = tx_valid_o & tx_ready_i;

    // NOTE: outputs are gated by rst_i so they read as reset values during the
    // reset cycle itself, before the synchronous reset has reached the state.
    assign busy_o = !rst_i && (state != S_IDLE);
    assign err_o  = !rst_i && err_q;

    // Handshake and data steering per state; echo is a pure combinational path.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        rx_ready_o = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = '0;
        if (!rst_i) begin
            case (state)
                S_ECHO: begin
                    rx_ready_o = tx_ready_i;
                    tx_valid_o = rx_valid_i;
                    tx_data_o  = rx_data_i;
                end
                S_RESULT: begin
                    tx_valid_o = 1'b1;
                    case (tx_idx)
                        2'd0:    tx_data_o = acc[7:0];
                        2'd1:    tx_data_o = acc[15:8];
                        2'd2:    tx_data_o = acc[23:16];
                        default: tx_data_o = acc[31:24];
                    endcase
                end
                default: rx_ready_o = 1'b1;
            endcase
        end
    end

    // Packet parser, payload counter and accumulator; only transfers advance.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // right-hand side below reads the value from before this edge.
        if (rst_i) begin
            state    <= S_IDLE;
            opcode   <= '0;
            len_lo   <= '0;
            cnt      <= '0;
            acc      <= '0;
            part     <= '0;
            byte_idx <= '0;
            tx_idx   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: if (rx_fire) begin
                    opcode <= rx_data_i;
                    state  <= S_RSVD;
                end
                S_RSVD: if (rx_fire) state <= S_LEN_LO;
                S_LEN_LO: if (rx_fire) begin
                    len_lo <= rx_data_i;
                    state  <= S_LEN_HI;
                end
                S_LEN_HI: if (rx_fire) begin
                    cnt      <= pay_w;
                    byte_idx <= '0;
                    tx_idx   <= '0;
                    if (len_w < 16'd4) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else if (opcode == OP_ECHO) begin
                        state <= (pay_w == 16'd0) ? S_IDLE : S_ECHO;
                    end else if (is_arith && pay_w != 16'd0 && pay_w[1:0] == 2'd0) begin
                        acc   <= (opcode == OP_MUL) ? 32'd1 : 32'd0;
                        state <= S_ACCUM;
                    end else begin
                        err_q <= 1'b1;
                        state <= (pay_w == 16'd0) ? S_IDLE : S_DRAIN;
                    end
                end
                S_ECHO, S_DRAIN: if (rx_fire) begin
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd1) state <= S_IDLE;
                end
                S_ACCUM: if (rx_fire) begin
                    cnt      <= cnt - 16'd1;
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    part[7:0]   <= rx_data_i;
                        2'd1:    part[15:8]  <= rx_data_i;
                        2'd2:    part[23:16] <= rx_data_i;
                        default: acc         <= acc_next;
                    endcase
                    if (cnt == 16'd1) state <= S_RESULT;
                end
                S_RESULT: if (tx_fire) begin
                    tx_idx <= tx_idx + 2'd1;
                    if (tx_idx == 2'd3) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_packet_engine.sv
// Self-checking bench for alu_packet_engine: a packet-level reference model
// predicts the tx byte stream and error pulses. A single monitor compares the
// DUT against those predictions every cycle.
`timescale 1ns/1ps
module tb_alu_packet_engine;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       err_o;

    alu_packet_engine #(.DATA_WIDTH(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   tx_mode  = 0;   // 0 always ready, 1 random, 2 toggle, 3 one-in-six, 4 never
    bit   gap_en   = 0;
    bit   stalled  = 0;
    bit   err_arm  = 0;
    bit   err_exp  = 0;
    bit   res_arm  = 0;
    bit   idle_arm = 0;
    bit   echo_phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole packet in, expected error flag and tx bytes out.
    function automatic void model(input byte_q_t pkt, output bit err, output byte_q_t out);
        int          len;
        int          p;
        logic [31:0] acc;
        logic [31:0] word;
        out = {};
        err = 0;
        len = int'(pkt[2]) + 256 * int'(pkt[3]);
        p   = len - 4;
        if (len < 4) begin
            err = 1;
        end else if (pkt[0] == 8'hEC) begin
            for (int i = 0; i < p; i++) out.push_back(pkt[4 + i]);
        end else if (pkt[0] == 8'hA0 || pkt[0] == 8'h88) begin
            if (p == 0 || p % 4 != 0) begin
                err = 1;
            end else begin
                acc = (pkt[0] == 8'h88) ? 32'd1 : 32'd0;
                for (int w = 0; w < p / 4; w++) begin
                    word = {pkt[4*w+7], pkt[4*w+6], pkt[4*w+5], pkt[4*w+4]};
                    acc  = (pkt[0] == 8'hA0) ? acc + word : acc * word;
                end
                for (int b = 0; b < 4; b++) out.push_back(acc[8*b +: 8]);
            end
        end else begin
            err = 1;
        end
    endfunction

    // Pin the model against hand-computed results.
    task automatic pin_model(input string name, input byte_q_t pkt, input bit lit_err,
                             input byte_q_t lit);
        bit      err;
        byte_q_t out;
        model(pkt, err, out);
        check({name, "_model_err"}, err, lit_err);
        check({name, "_model_len"}, out.size(), lit.size());
        for (int i = 0; i < lit.size() && i < out.size(); i++)
            check({name, "_model_byte"}, out[i], lit[i]);
    endtask

    // tx_ready_i pattern generator.
    initial begin
        int cyc = 0;
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            case (tx_mode)
                0:       tx_ready_i = 1'b1;
                1:       tx_ready_i = 1'($urandom_range(0, 1));
                2:       tx_ready_i = ~tx_ready_i;
                3:       tx_ready_i = (cyc % 6 == 5);
                default: tx_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: compares DUT outputs on every cycle out of reset.
    initial begin
        bit         prev_hold = 0;
        logic [7:0] prev_data = '0;
        exp_t       e;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    check("tx_hold_valid", tx_valid_o, 1);
                    check("tx_hold_data", tx_data_o, prev_data);
                end
                if (err_arm) begin
                    check("err_pulse", err_o, err_exp);
                    err_arm = 0;
                end else if (err_o) begin
                    check("err_spurious", err_o, 0);
                end
                if (res_arm) begin
                    check("result_latency", tx_valid_o, 1);
                    res_arm = 0;
                end
                if (idle_arm) begin
                    check("idle_busy", busy_o, 0);
                    check("idle_rx_ready", rx_ready_o, 1);
                    idle_arm = 0;
                end
                if (echo_phase && rx_valid_i) begin
                    check("echo_ready_mirror", rx_ready_o, tx_ready_i);
                    check("echo_valid", tx_valid_o, 1);
                    check("echo_data", tx_data_o, rx_data_i);
                end
                if (tx_valid_o && tx_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_unexpected: got byte %h, expected no tx (t=%0t)",
                                 tx_data_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", tx_data_o, e.data);
                        if (e.last) idle_arm = 1;
                    end
                end
                prev_hold = tx_valid_o && !tx_ready_i;
                prev_data = tx_data_o;
            end
        end
    end

    // Offer one byte and hold it until the DUT takes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n    = 0;
        bit done = 0;
        if (stalled) return;
        if (gap_en) begin
            int g = $urandom_range(0, 2);
            repeat (g) begin
                @(posedge clk_i);
                #1;
            end
        end
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!done && n < 2000) begin
            @(negedge clk_i);
            done = rx_ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        rx_valid_i = 1'b0;
        check("rx_accept_in_time", done, 1);
        if (!done) stalled = 1;
    endtask

    // Send a full packet, queueing the model's expected bytes and timing checks.
    task automatic run_packet(input byte_q_t pkt);
        bit      err;
        byte_q_t out;
        int      kind;   // 0 no tx, 1 echo, 2 result
        exp_t    e;
        model(pkt, err, out);
        kind = (out.size() == 0) ? 0 : ((pkt[0] == 8'hEC) ? 1 : 2);
        foreach (out[i]) begin
            e.data = out[i];
            e.last = (i == out.size() - 1);
            exp_q.push_back(e);
        end
        for (int i = 0; i < pkt.size(); i++) begin
            if (kind == 1 && i == 4) echo_phase = 1;
            send_byte(pkt[i]);
            if (i == 3) begin
                err_exp = err;
                err_arm = 1;
            end
            if (i == pkt.size() - 1) begin
                echo_phase = 0;
                if (kind == 2) res_arm = 1;
                if (kind == 0) idle_arm = 1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((exp_q.size() != 0 || busy_o) && n < 1000);
        check({name, "_settled"}, (n < 1000), 1);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_busy"}, busy_o, 0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        echo_phase = 0;
        @(negedge clk_i);
        check("rst_rx_ready", rx_ready_o, 0);
        check("rst_tx_valid", tx_valid_o, 0);
        check("rst_tx_data", tx_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        err_arm  = 0;
        res_arm  = 0;
        idle_arm = 0;
        @(negedge clk_i);
        check("post_rst_rx_ready", rx_ready_o, 1);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_tx_valid", tx_valid_o, 0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t pkt_add, pkt_mul, pkt_echo, pkt_bad, pkt_add5, pkt_short, pkt_e0, pkt;
        int      kind, p, len;
        logic [7:0] op;

        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = '0;
        do_reset();

        pkt_add   = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                      8'h02, 8'h00, 8'h00, 8'h00};
        pkt_mul   = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                      8'h02, 8'h00, 8'h00, 8'h00};
        pkt_echo  = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h61, 8'h62, 8'h63};
        pkt_bad   = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        pkt_add5  = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        pkt_short = '{8'hA0, 8'h00, 8'h02, 8'h00};
        pkt_e0    = '{8'hEC, 8'h00, 8'h04, 8'h00};

        pin_model("add",   pkt_add,   0, '{8'h03, 8'h00, 8'h00, 8'h00});
        pin_model("mul",   pkt_mul,   0, '{8'hFE, 8'hFF, 8'hFF, 8'hFF});
        pin_model("echo",  pkt_echo,  0, '{8'h61, 8'h62, 8'h63});
        pin_model("bad",   pkt_bad,   1, '{});
        pin_model("add5",  pkt_add5,  0, '{8'h05, 8'h00, 8'h00, 8'h00});
        pin_model("short", pkt_short, 1, '{});

        // Directed scenarios.
        tx_mode = 0;
        run_packet(pkt_add);
        wait_idle("add");
        run_packet(pkt_mul);
        wait_idle("mul");
        tx_mode = 3;
        run_packet(pkt_mul);
        wait_idle("mul_bp");
        tx_mode = 2;
        run_packet(pkt_echo);
        wait_idle("echo_bp");
        tx_mode = 0;
        run_packet(pkt_bad);
        run_packet(pkt_add5);
        run_packet(pkt_short);
        wait_idle("malformed");

        // Reset in the middle of a packet, then a clean add.
        foreach (pkt_add[i]) if (i < 6) send_byte(pkt_add[i]);
        do_reset();
        run_packet(pkt_add);
        wait_idle("after_rst");

        // Back-to-back: empty echo immediately followed by add.
        run_packet(pkt_e0);
        run_packet(pkt_add);
        wait_idle("b2b");

        // Reset while a result is waiting on tx_ready_i.
        tx_mode = 4;
        run_packet(pkt_add);
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        do_reset();
        tx_mode = 0;
        repeat (10) begin
            @(posedge clk_i);
            #1;
        end
        run_packet(pkt_echo);
        wait_idle("after_rst_result");

        // Randomized packet mix with random gaps and backpressure.
        tx_mode = 1;
        gap_en  = 1;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin op = 8'hEC; p = $urandom_range(0, 8); end
                1: begin op = 8'hA0; p = 4 * $urandom_range(1, 4); end
                2: begin op = 8'h88; p = 4 * $urandom_range(1, 4); end
                3: begin
                    op = ($urandom_range(0, 1) != 0) ? 8'hA0 : 8'h88;
                    p  = $urandom_range(0, 9);
                    if (p % 4 == 0 && p != 0) p++;
                end
                4: begin
                    do op = 8'($urandom_range(0, 255));
                    while (op == 8'hEC || op == 8'hA0 || op == 8'h88);
                    p = $urandom_range(0, 5);
                end
                default: begin op = 8'($urandom_range(0, 255)); p = -4; end
            endcase
            len = (kind == 5) ? $urandom_range(0, 3) : p + 4;
            pkt = '{op, 8'($urandom_range(0, 255)), 8'(len), 8'(len >> 8)};
            for (int i = 0; i < p; i++) pkt.push_back(8'($urandom_range(0, 255)));
            run_packet(pkt);
        end
        wait_idle("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
